ahb_uart: RTL and testbench

// - Memory-mapped UART peripheral on the SoC bus (bus_protocol_if, modport peripheral_vital).
// - Serialises 8N1 frames on tx and deserialises frames from rx, with optional cts/rts hardware flow control.
// - Software programs the baud divider, writes TX bytes and polls or reads RX status and data through a small register map.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/bus_protocol_if.sv | 22 ++
 rtl/uart_rx.sv | 86 ++++++++
 rtl/ahb_uart.sv | 170 +++++++++++++++++
 tb/tb_ahb_uart.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, register offsets and FSM state types for the UART peripheral.
package uart_pkg;

    localparam logic [15:0] DEFAULT_DIV = 16'd16;
    localparam logic [15:0] MIN_DIV     = 16'd4;

    localparam logic [31:0] RXSTATE_OFF = 32'h00;
    localparam logic [31:0] RXDATA_OFF  = 32'h04;
    localparam logic [31:0] TXSTATE_OFF = 32'h08;
    localparam logic [31:0] TXDATA_OFF  = 32'h0C;
    localparam logic [31:0] FLOW_OFF    = 32'h10;
    localparam logic [31:0] DIV_OFF     = 32'h18;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/bus_protocol_if.sv
// Single-cycle SoC register bus; the peripheral side never stalls.
interface bus_protocol_if;

    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport peripheral_vital (
        input  addr, wen, ren, wdata,
        output rdata, error, request_stall
    );

    modport cpu (
        output addr, wen, ren, wdata,
        input  rdata, error, request_stall
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchroniser, start-glitch rejection, centre sampling.
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        nReset,
    input  logic        rx_i,
    input  logic [15:0] div_i,
    output logic [7:0]  data_o,
    output logic        done_o,
    output logic        frame_err_o
);

    logic        sync1_q, sync2_q, prev_q;
    rx_state_t   state_q;
    logic [15:0] cnt_q, div_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        done_q, ferr_q;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            div_q   <= DEFAULT_DIV;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                        div_q   <= eff_div(div_i);
                    end
                end
                RX_START: begin
                    // Half a bit after the edge the line must still be low.
                    if (cnt_q == (div_q >> 1) - 16'd1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == div_q - 16'd1) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == div_q - 16'd1) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        done_q  <= sync2_q;
                        ferr_q  <= ~sync2_q;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign data_o      = shift_q;
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/ahb_uart.sv
// Memory-mapped 8N1 UART: register file, bus decode, TX FSM and optional cts/rts flow control.
module ahb_uart
    import uart_pkg::*;
(
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     rx,
    output logic                     tx,
    input  logic                     cts,
    output logic                     rts,
    bus_protocol_if.peripheral_vital bp
);

    logic [15:0] div_q;
    logic        flow_q, rx_valid_q, overrun_q, frame_err_q, rts_q;
    logic [7:0]  rx_data_q;
    tx_state_t   tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        tx_q, tx_busy_q;

    logic        sel_rxstate, sel_rxdata, sel_txstate, sel_txdata, sel_flow, sel_div;
    logic        tx_wr, tx_go, rx_rd, rx_done, rx_ferr;
    logic [7:0]  rx_byte;
    logic [31:0] rdata_c;
    logic        err_c;

    uart_rx u_rx (
        .clk         (clk),
        .nReset      (nReset),
        .rx_i        (rx),
        .div_i       (div_q),
        .data_o      (rx_byte),
        .done_o      (rx_done),
        .frame_err_o (rx_ferr)
    );

    assign sel_rxstate = (bp.addr == RXSTATE_OFF);
    assign sel_rxdata  = (bp.addr == RXDATA_OFF);
    assign sel_txstate = (bp.addr == TXSTATE_OFF);
    assign sel_txdata  = (bp.addr == TXDATA_OFF);
    assign sel_flow    = (bp.addr == FLOW_OFF);
    assign sel_div     = (bp.addr == DIV_OFF);

    assign tx_wr = bp.wen && sel_txdata && !tx_busy_q;
    assign tx_go = !flow_q || cts;
    assign rx_rd = bp.ren && sel_rxdata;

    always_comb begin
        rdata_c = '0;
        err_c   = 1'b0;
        if (bp.ren) begin
            if (sel_rxstate) rdata_c = {29'b0, frame_err_q, overrun_q, rx_valid_q};
            if (sel_rxdata)  rdata_c = {24'b0, rx_data_q};
            if (sel_txstate) rdata_c = {31'b0, tx_busy_q};
            if (sel_flow)    rdata_c = {31'b0, flow_q};
            if (sel_div)     rdata_c = {16'b0, div_q};
        end
        if ((bp.ren || bp.wen) &&
            !(sel_rxstate || sel_rxdata || sel_txstate || sel_txdata || sel_flow || sel_div))
            err_c = 1'b1;
        if (bp.wen && (sel_rxdata || sel_txstate)) err_c = 1'b1;
        if (bp.wen && sel_txdata && tx_busy_q)     err_c = 1'b1;
    end

    assign bp.rdata         = rdata_c;
    assign bp.error         = err_c;
    assign bp.request_stall = 1'b0;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            div_q       <= DEFAULT_DIV;
            flow_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
            rts_q       <= 1'b0;
        end else begin
            rts_q <= flow_q ? ~rx_valid_q : 1'b1;
            if (bp.wen && sel_rxstate) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (bp.wen && sel_flow) flow_q <= bp.wdata[0];
            if (bp.wen && sel_div)  div_q  <= bp.wdata[15:0];
            // A read racing a fresh byte frees the slot, so the new byte is kept without overrun.
            if (rx_done) begin
                if (rx_valid_q && !rx_rd) begin
                    overrun_q <= 1'b1;
                end else begin
                    rx_data_q  <= rx_byte;
                    rx_valid_q <= 1'b1;
                end
            end else if (rx_rd) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_ferr) frame_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DEFAULT_DIV;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_wr) begin
                        tx_shift_q <= bp.wdata[7:0];
                        tx_busy_q  <= 1'b1;
                    end
                    // A pending byte held back by cts stays here with tx_busy set.
                    if ((tx_wr || tx_busy_q) && tx_go) begin
                        tx_state_q <= TX_START;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_div_q   <= eff_div(div_q);
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == tx_div_q - 16'd1) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == tx_div_q - 16'd1) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == tx_div_q - 16'd1) begin
                        tx_cnt_q   <= '0;
                        tx_busy_q  <= 1'b0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx  = tx_q;
    assign rts = rts_q;

endmodule

// File: tb/tb_ahb_uart.sv
// Scoreboard bench for ahb_uart: bus responses and serial TX frames are checked by monitors.
module tb_ahb_uart;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic rx = 1'b1;
    logic cts = 1'b0;
    logic tx, rts;

    bus_protocol_if bp();

    ahb_uart dut (
        .clk    (clk),
        .nReset (nReset),
        .rx     (rx),
        .tx     (tx),
        .cts    (cts),
        .rts    (rts),
        .bp     (bp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [32:0] exp;
    } bus_exp_t;

    typedef struct {
        logic [7:0] data;
        int         div;
    } tx_exp_t;

    bus_exp_t bus_q[$];
    tx_exp_t  txf_q[$];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one access for exactly one cycle; caller is at posedge+1.
    task automatic bus_op(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        bus_exp_t e;
        e.name = name;
        e.exp  = {exp_err, exp_rd};
        bus_q.push_back(e);
        bp.addr  = a;
        bp.wen   = wr;
        bp.ren   = !wr;
        bp.wdata = wr ? wd : 32'h0;
        @(posedge clk);
        #1;
        bp.addr  = '0;
        bp.wen   = 1'b0;
        bp.ren   = 1'b0;
        bp.wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus_op(1'b0, a, 32'h0, exp, 1'b0, name);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_err, input string name);
        bus_op(1'b1, a, d, 32'h0, exp_err, name);
    endtask

    task automatic send_rx(input logic [7:0] d, input int div, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            idle(div);
        end
        rx = 1'b1;
    endtask

    always @(negedge clk) begin : bus_monitor
        bus_exp_t e;
        if (bp.ren || bp.wen) begin
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: access at addr %h with no expectation queued", bp.addr);
            end else begin
                e = bus_q.pop_front();
                check(e.name, {bp.error, bp.rdata}, e.exp);
            end
        end
    end

    initial begin : tx_monitor
        logic       last;
        logic [9:0] bits;
        tx_exp_t    e;
        int         bad;
        last = 1'b1;
        forever begin
            @(negedge clk);
            if (last === 1'b1 && tx === 1'b0) begin
                if (txf_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: start bit seen with no frame queued");
                end else begin
                    e = txf_q.pop_front();
                    bits = {1'b1, e.data, 1'b0};
                    for (int b = 0; b < 10; b++) begin
                        bad = 0;
                        for (int c = 0; c < e.div; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (tx !== bits[b]) bad++;
                        end
                        check($sformatf("tx_%02h_bit%0d_badcycles", e.data, b), 33'(bad), 33'd0);
                    end
                end
            end
            last = tx;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_exp_t f;
        bp.addr  = '0;
        bp.wen   = 1'b0;
        bp.ren   = 1'b0;
        bp.wdata = '0;

        idle(3);
        check("tx_in_reset", 33'(tx), 33'd1);
        check("rts_in_reset", 33'(rts), 33'd0);
        nReset = 1'b1;
        idle(2);
        check("rts_after_reset", 33'(rts), 33'd1);

        rd(32'h00, 32'h0, "rxstate_reset");
        rd(32'h18, 32'd16, "div_reset");
        rd(32'h08, 32'h0, "txstate_reset");
        rd(32'h10, 32'h0, "flow_reset");
        bus_op(1'b0, 32'h14, 32'h0, 32'h0, 1'b1, "unmapped_read");
        wr(32'h04, 32'h12, 1'b1, "write_rxdata_ro");
        wr(32'h08, 32'h01, 1'b1, "write_txstate_ro");

        // TX at DIV=15, with a rejected write mid-frame
        wr(32'h18, 32'h0F, 1'b0, "write_div15");
        rd(32'h18, 32'h0F, "div_readback");
        f.data = 8'hA5; f.div = 15;
        txf_q.push_back(f);
        wr(32'h0C, 32'hA5, 1'b0, "write_txdata");
        rd(32'h08, 32'h1, "txbusy_cycle0");
        wr(32'h0C, 32'h5A, 1'b1, "write_txdata_busy");
        idle(146);
        rd(32'h08, 32'h1, "txbusy_cycle148");
        rd(32'h08, 32'h1, "txbusy_cycle149");
        rd(32'h08, 32'h0, "txbusy_cycle150");
        idle(5);
        check("tx_idle_after_frame", 33'(tx), 33'd1);

        // RX at DIV=16
        wr(32'h18, 32'd16, 1'b0, "write_div16");
        send_rx(8'h3C, 16, 1'b1);
        idle(4);
        rd(32'h00, 32'h1, "rx_valid");
        rd(32'h04, 32'h3C, "rxdata_3c");
        rd(32'h00, 32'h0, "rx_valid_cleared");

        send_rx(8'h11, 16, 1'b1);
        idle(4);
        rd(32'h00, 32'h1, "rx_valid_11");
        send_rx(8'h22, 16, 1'b1);
        idle(4);
        rd(32'h00, 32'h3, "overrun");
        rd(32'h04, 32'h11, "rxdata_kept_first");
        send_rx(8'h44, 16, 1'b0);
        idle(20);
        rd(32'h00, 32'h6, "frame_err");
        wr(32'h00, 32'h0, 1'b0, "clear_rxstate");
        rd(32'h00, 32'h0, "rxstate_cleared");

        // Flow control
        wr(32'h10, 32'h1, 1'b0, "write_flow");
        rd(32'h10, 32'h1, "flow_readback");
        idle(2);
        check("rts_flow_empty", 33'(rts), 33'd1);
        f.data = 8'h96; f.div = 16;
        txf_q.push_back(f);
        wr(32'h0C, 32'h96, 1'b0, "write_txdata_flow");
        idle(40);
        check("tx_held_by_cts", 33'(tx), 33'd1);
        rd(32'h08, 32'h1, "txbusy_waiting_cts");
        cts = 1'b1;
        idle(20);
        cts = 1'b0;
        idle(160);
        rd(32'h08, 32'h0, "txbusy_flow_done");

        send_rx(8'h5A, 16, 1'b1);
        idle(4);
        check("rts_rx_full", 33'(rts), 33'd0);
        rd(32'h04, 32'h5A, "rxdata_5a");
        idle(2);
        check("rts_rx_drained", 33'(rts), 33'd1);

        idle(5);
        check("queues_drained", 33'(bus_q.size() + txf_q.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
